// File: rtl/int_to_float_pkg.sv
// Shared single-precision float definitions: FSM encodings, field positions
// and constants used by the integer-to-float converter and its rounding stage.
package int_to_float_pkg;

  localparam logic [2:0] ST_GET_A     = 3'd0;
  localparam logic [2:0] ST_CONVERT   = 3'd1;
  localparam logic [2:0] ST_NORMALISE = 3'd2;
  localparam logic [2:0] ST_ROUND     = 3'd3;
  localparam logic [2:0] ST_PACK      = 3'd4;
  localparam logic [2:0] ST_PUT_Z     = 3'd5;

  localparam logic [7:0]  EXP_BIAS = 8'd127;
  localparam int          SIGN_BIT = 31;
  localparam int          EXP_MSB  = 30;
  localparam int          EXP_LSB  = 23;
  localparam int          MAN_MSB  = 22;
  localparam logic [31:0] ZERO_F32 = 32'h0000_0000;

  // Unbiased exponent of a 32-bit integer magnitude spans 0..32.
  localparam int                    EXP_WIDTH = 6;
  localparam logic [EXP_WIDTH-1:0]  EXP_START = 6'd31;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 24-bit significand with guard/round/sticky;
// a carry out of the significand renormalises to 1.0 and bumps the exponent.
module fp_round_rne
  import int_to_float_pkg::*;
#(
  parameter int EXP_W = EXP_WIDTH
) (
  input  logic [23:0]      man_i,
  input  logic             guard_i,
  input  logic             rnd_i,
  input  logic             sticky_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic [23:0]      man_o,
  output logic [EXP_W-1:0] exp_o
);

  logic inc;
  assign inc = guard_i & (rnd_i | sticky_i | man_i[0]);

  always_comb begin
    man_o = man_i;
    exp_o = exp_i;
    if (inc) begin
      if (&man_i) begin
        man_o = 24'h80_0000;
        exp_o = exp_i + {{(EXP_W-1){1'b0}}, 1'b1};
      end else begin
        man_o = man_i + 24'd1;
      end
    end
  end

endmodule

// File: rtl/int_to_float.sv
// Multi-cycle signed 32-bit integer to IEEE-754 single converter with
// stb/ack handshakes; normalises one bit per cycle, then rounds and packs.
module int_to_float
  import int_to_float_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] int_to_float_a,
  input  logic        int_to_float_a_stb,
  output logic        int_to_float_a_ack,
  output logic [31:0] int_to_float_z,
  output logic        int_to_float_z_stb,
  input  logic        int_to_float_z_ack
);

  logic [2:0]           state_q, state_d;
  logic                 a_ack_q, a_ack_d;
  logic                 z_stb_q, z_stb_d;
  logic [31:0]          z_q, z_d;
  logic [31:0]          a_q, a_d;
  logic                 sign_q, sign_d;
  logic [31:0]          mag_q, mag_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [23:0]          man_q, man_d;

  logic [23:0]          rnd_man;
  logic [EXP_WIDTH-1:0] rnd_exp;
  logic [7:0]           exp_biased;

  fp_round_rne #(.EXP_W(EXP_WIDTH)) u_round (
    .man_i   (mag_q[31:8]),
    .guard_i (mag_q[7]),
    .rnd_i   (mag_q[6]),
    .sticky_i(|mag_q[5:0]),
    .exp_i   (exp_q),
    .man_o   (rnd_man),
    .exp_o   (rnd_exp)
  );

  assign exp_biased = {{(8-EXP_WIDTH){1'b0}}, exp_q} + EXP_BIAS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_GET_A;
      a_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
      z_q     <= ZERO_F32;
    end else begin
      state_q <= state_d;
      a_ack_q <= a_ack_d;
      z_stb_q <= z_stb_d;
      z_q     <= z_d;
    end
  end

  // Working registers carry no reset: every path through CONVERT rewrites them.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    sign_q <= sign_d;
    mag_q  <= mag_d;
    exp_q  <= exp_d;
    man_q  <= man_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_GET_A:     if (int_to_float_a_stb && a_ack_q) state_d = ST_CONVERT;
      ST_CONVERT:   state_d = (a_q == 32'd0) ? ST_PUT_Z : ST_NORMALISE;
      ST_NORMALISE: if (mag_q[31]) state_d = ST_ROUND;
      ST_ROUND:     state_d = ST_PACK;
      ST_PACK:      state_d = ST_PUT_Z;
      ST_PUT_Z:     if (z_stb_q && int_to_float_z_ack) state_d = ST_GET_A;
      default:      state_d = ST_GET_A;
    endcase
  end

  always_comb begin
    a_ack_d = (state_d == ST_GET_A);
    z_stb_d = (state_d == ST_PUT_Z);
    z_d     = z_q;
    a_d     = a_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    man_d   = man_q;
    case (state_q)
      ST_GET_A: begin
        if (int_to_float_a_stb && a_ack_q) a_d = int_to_float_a;
      end
      ST_CONVERT: begin
        sign_d = a_q[31];
        // -(2^31) wraps back to 0x80000000, which is already the right magnitude.
        mag_d  = a_q[31] ? (~a_q + 32'd1) : a_q;
        exp_d  = EXP_START;
        if (a_q == 32'd0) z_d = ZERO_F32;
      end
      ST_NORMALISE: begin
        if (!mag_q[31]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - {{(EXP_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_ROUND: begin
        man_d = rnd_man;
        exp_d = rnd_exp;
      end
      ST_PACK: begin
        z_d[SIGN_BIT]        = sign_q;
        z_d[EXP_MSB:EXP_LSB] = exp_biased;
        z_d[MAN_MSB:0]       = man_q[22:0];
      end
      default: ;
    endcase
  end

  assign int_to_float_a_ack = a_ack_q;
  assign int_to_float_z_stb = z_stb_q;
  assign int_to_float_z     = z_q;

endmodule

// File: tb/tb_int_to_float.sv
// Directed and randomised checks of int_to_float results, latency and
// handshake behaviour against a shift-and-remainder reference model.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = 32'd0;
  logic        a_stb = 1'b0;
  logic        a_ack;
  logic [31:0] z;
  logic        z_stb;
  logic        z_ack = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  int_to_float dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .int_to_float_a    (a),
    .int_to_float_a_stb(a_stb),
    .int_to_float_a_ack(a_ack),
    .int_to_float_z    (z),
    .int_to_float_z_stb(z_stb),
    .int_to_float_z_ack(z_ack)
  );

  // Reference: locate MSB, truncate, then round on the exact remainder.
  function automatic void ref_conv(input logic [31:0] v, output logic [31:0] f,
                                   output int lat);
    logic        s;
    logic [63:0] mag, q, rem, half;
    int          p, sh;
    if (v == 32'd0) begin
      f = 32'd0;
      lat = 1;
      return;
    end
    s = v[31];
    mag = {32'd0, (s ? (32'd0 - v) : v)};
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    lat = (31 - p) + 4;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh = p - 23;
      q = mag >> sh;
      rem = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    f = {s, 8'(p + 127), q[22:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one conversion and reports observations; callers do the comparing.
  task automatic run_conv(input logic [31:0] val, input int pre_gap, input int ack_gap,
                          output logic [31:0] zr, output int lat, output bit timeout,
                          output bit hold_ok, output bit ack_low_ok, output bit post_ok);
    int w;
    timeout = 1'b0; hold_ok = 1'b1; ack_low_ok = 1'b1; post_ok = 1'b1;
    lat = 0; zr = 32'd0;
    repeat (pre_gap) step();
    w = 0;
    while (!a_ack && w < 60) begin
      step();
      w++;
    end
    if (!a_ack) begin
      timeout = 1'b1;
      return;
    end
    a = val;
    a_stb = 1'b1;
    step();
    a_stb = 1'b0;
    a = $urandom;
    while (!z_stb && lat < 100) begin
      if (a_ack) ack_low_ok = 1'b0;
      step();
      lat++;
    end
    if (!z_stb) begin
      timeout = 1'b1;
      return;
    end
    zr = z;
    repeat (ack_gap) begin
      if (z !== zr || z_stb !== 1'b1 || a_ack !== 1'b0) hold_ok = 1'b0;
      step();
    end
    if (z !== zr || z_stb !== 1'b1 || a_ack !== 1'b0) hold_ok = 1'b0;
    z_ack = 1'b1;
    step();
    z_ack = 1'b0;
    if (z_stb !== 1'b0 || a_ack !== 1'b1) post_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++;
    if ({a_ack, z_stb, z} !== 34'd0) begin
      bad++;
      $display("FAIL reset_state: got ack=%b stb=%b z=%h want 0 0 00000000", a_ack, z_stb, z);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (a_ack !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_ack: got %b want 0", a_ack);
    end
    step();
    total++;
    if (a_ack !== 1'b1) begin
      bad++;
      $display("FAIL first_edge_ack: got %b want 1", a_ack);
    end
  endtask

  task automatic test_one();
    logic [31:0] zr; int lat; bit to, h, al, po;
    run_conv(32'd1, 0, 0, zr, lat, to, h, al, po);
    total++;
    if (to || zr !== 32'h3F80_0000) begin
      bad++;
      $display("FAIL one_value: got %h (timeout=%b) want 3f800000", zr, to);
    end
    total++;
    if (lat !== 35) begin
      bad++;
      $display("FAIL one_latency: got %0d want 35", lat);
    end
    total++;
    if (!al || !po) begin
      bad++;
      $display("FAIL one_ack: got ack_low=%b post=%b want 1 1", al, po);
    end
  endtask

  task automatic test_zero_neg();
    logic [31:0] zr; int lat; bit to, h, al, po;
    run_conv(32'd0, 0, 0, zr, lat, to, h, al, po);
    total++;
    if (to || zr !== 32'h0000_0000 || lat !== 1) begin
      bad++;
      $display("FAIL zero: got %h lat=%0d want 00000000 lat=1", zr, lat);
    end
    run_conv(32'hFFFF_FFFF, 0, 0, zr, lat, to, h, al, po);
    total++;
    if (to || zr !== 32'hBF80_0000 || lat !== 35) begin
      bad++;
      $display("FAIL minus_one: got %h lat=%0d want bf800000 lat=35", zr, lat);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] vin [4] = '{32'h0100_0001, 32'h0100_0003, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] vexp[4] = '{32'h4B80_0000, 32'h4B80_0002, 32'h4F00_0000, 32'hCF00_0000};
    int          vlat[4] = '{11, 11, 5, 4};
    logic [31:0] zr; int lat; bit to, h, al, po;
    for (int i = 0; i < 4; i++) begin
      run_conv(vin[i], 1, 0, zr, lat, to, h, al, po);
      total++;
      if (to || zr !== vexp[i] || lat !== vlat[i]) begin
        bad++;
        $display("FAIL round_%h: got %h lat=%0d want %h lat=%0d", vin[i], zr, lat, vexp[i], vlat[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] zr; int lat; bit to, h, al, po;
    run_conv(32'd5, 0, 10, zr, lat, to, h, al, po);
    total++;
    if (to || zr !== 32'h40A0_0000) begin
      bad++;
      $display("FAIL bp_value: got %h want 40a00000", zr);
    end
    total++;
    if (!h) begin
      bad++;
      $display("FAIL bp_hold: got unstable z/stb/ack want stable");
    end
    total++;
    if (!po) begin
      bad++;
      $display("FAIL bp_post: got stb=%b ack=%b want 0 1", z_stb, a_ack);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] zr; int lat; bit to, h, al, po;
    int w;
    // Reset while a nonzero result is being held under back-pressure.
    w = 0;
    while (!a_ack && w < 60) begin step(); w++; end
    a = 32'd7; a_stb = 1'b1; step(); a_stb = 1'b0;
    w = 0;
    while (!z_stb && w < 60) begin step(); w++; end
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_ack, z_stb, z} !== 34'd0) begin
      bad++;
      $display("FAIL reset_in_put: got ack=%b stb=%b z=%h want 0 0 00000000", a_ack, z_stb, z);
    end
    step();
    rst_n = 1'b1;
    step();
    // Reset mid-NORMALISE of a = 1.
    a = 32'd1; a_stb = 1'b1; step(); a_stb = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_ack, z_stb, z} !== 34'd0) begin
      bad++;
      $display("FAIL reset_in_norm: got ack=%b stb=%b z=%h want 0 0 00000000", a_ack, z_stb, z);
    end
    repeat (3) step();
    total++;
    if (z_stb !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_partial: got stb=%b want 0", z_stb);
    end
    rst_n = 1'b1;
    step();
    run_conv(32'h0000_0400, 0, 0, zr, lat, to, h, al, po);
    total++;
    if (to || zr !== 32'h4480_0000 || lat !== 25) begin
      bad++;
      $display("FAIL after_reset: got %h lat=%0d want 44800000 lat=25", zr, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] v, ez, zr; int el, lat; bit to, h, al, po;
    for (int n = 0; n < 1000; n++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
      ref_conv(v, ez, el);
      run_conv(v, $urandom_range(0, 3), $urandom_range(0, 3), zr, lat, to, h, al, po);
      total++;
      if (to || zr !== ez) begin
        bad++;
        $display("FAIL rand_value a=%h: got %h want %h", v, zr, ez);
      end
      total++;
      if (lat !== el) begin
        bad++;
        $display("FAIL rand_latency a=%h: got %0d want %0d", v, lat, el);
      end
      total++;
      if (!h || !al || !po) begin
        bad++;
        $display("FAIL rand_handshake a=%h: got hold=%b ack_low=%b post=%b want 1 1 1", v, h, al, po);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one();
    test_zero_neg();
    test_rounding();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
